riscv_wbu: RTL and testbench

//   Writeback stage of the RISC-V pipeline, directly downstream of riscv_lsu. Accepts retiring

---
 rtl/riscv_wbu_if.sv | 12 +
 rtl/riscv_wbu.sv | 100 ++++++++++
 tb/tb_riscv_wbu.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_wbu_if.sv
// Retire handshake carrying one instruction from the LSU into the writeback stage.
`timescale 1ns/1ps
interface riscv_wbu_if;
    logic        valid;
    logic        ready;
    logic [29:0] pc;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (output valid, pc, rd_addr, rd_data, input ready);
    modport slave  (input valid, pc, rd_addr, rd_data, output ready);
endinterface

// File: rtl/riscv_wbu.sv
// RISC-V writeback stage: register file, decode read ports, minstret counter and retire event.
// Optional RISCV_WBU_BYPASS_EN forwards the value being written straight to the decode read ports.
`timescale 1ns/1ps
module riscv_wbu #(
    parameter logic [29:0] RESET_PC_TAG = 30'h0
) (
    input  logic        clk_i,
    input  logic        reset_i,
    riscv_wbu_if.slave  retire_in,
    input  logic        halt_i,
    input  logic [4:0]  rs1_addr_i,
    output logic [31:0] rs1_data_o,
    input  logic [4:0]  rs2_addr_i,
    output logic [31:0] rs2_data_o,
    output logic [4:0]  hz_rd_addr_o,
    input  logic        instret_inhibit_i,
    input  logic        cnt_we_i,
    input  logic        cnt_hi_i,
    input  logic [31:0] cnt_data_i,
    output logic [63:0] instret_o,
    output logic        retire_valid_o,
    output logic [29:0] retire_pc_o,
    output logic [4:0]  retire_rd_addr_o
);

    logic        accept;
    logic        write_en;
    logic [31:0] regs [31:1];
    logic [63:0] instret_q;

    assign retire_in.ready = !halt_i;
    assign accept          = retire_in.valid && !halt_i;
    assign write_en        = accept && (retire_in.rd_addr != 5'd0);
    assign hz_rd_addr_o    = accept ? retire_in.rd_addr : 5'd0;
    assign instret_o       = instret_q;

    // NOTE: every architectural register is cleared by reset, so this array is built from flops rather than a RAM macro.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[retire_in.rd_addr] <= retire_in.rd_data;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        logic [31:0] data;
        data = '0;
        if (addr != 5'd0) begin
`ifdef RISCV_WBU_BYPASS_EN
            if (write_en && (addr == retire_in.rd_addr)) begin
                data = retire_in.rd_data;
            end else begin
                data = regs[addr];
            end
`else
            data = regs[addr];
`endif
        end
        return data;
    endfunction

    // NOTE: each always_comb output gets a default before any branch so no latch can be inferred.
    always_comb begin
        rs1_data_o = read_port(rs1_addr_i);
        rs2_data_o = read_port(rs2_addr_i);
    end

    // A CSR write owns the counter for its cycle; the retiring instruction is not counted then.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            instret_q <= '0;
        end else if (cnt_we_i) begin
            if (cnt_hi_i) begin
                instret_q[63:32] <= cnt_data_i;
            end else begin
                instret_q[31:0] <= cnt_data_i;
            end
        end else if (accept && !instret_inhibit_i) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            retire_valid_o   <= 1'b0;
            retire_pc_o      <= RESET_PC_TAG;
            retire_rd_addr_o <= '0;
        end else begin
            retire_valid_o <= accept;
            if (accept) begin
                retire_pc_o      <= retire_in.pc;
                retire_rd_addr_o <= retire_in.rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_riscv_wbu.sv
// Self-checking bench for riscv_wbu: directed vector table, randomized run against a reference model, mid-run reset.
`timescale 1ns/1ps
module tb_riscv_wbu;

    localparam logic [29:0] TAG = 30'h155;
`ifdef RISCV_WBU_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        valid, halt;
        logic [29:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  rs1, rs2;
        logic        inh, we, hi;
        logic [31:0] cd;
    } stim_t;

    typedef struct {
        logic        ready;
        logic [4:0]  hz;
        logic [31:0] rs1, rs2;
        logic        rv;
        logic [29:0] rpc;
        logic [4:0]  rrd;
        logic [63:0] instret;
    } obs_t;

    typedef struct {
        stim_t s;
        obs_t  e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt, inhibit, cnt_we, cnt_hi;
    logic [4:0]  rs1_addr, rs2_addr, hz_rd_addr, retire_rd_addr;
    logic [31:0] rs1_data, rs2_data, cnt_data;
    logic [63:0] instret;
    logic        retire_valid;
    logic [29:0] retire_pc;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [32];
    logic [63:0] m_cnt;
    logic [29:0] m_rpc;
    logic [4:0]  m_rrd;

    riscv_wbu_if bus ();

    riscv_wbu #(.RESET_PC_TAG(TAG)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .retire_in         (bus),
        .halt_i            (halt),
        .rs1_addr_i        (rs1_addr),
        .rs1_data_o        (rs1_data),
        .rs2_addr_i        (rs2_addr),
        .rs2_data_o        (rs2_data),
        .hz_rd_addr_o      (hz_rd_addr),
        .instret_inhibit_i (inhibit),
        .cnt_we_i          (cnt_we),
        .cnt_hi_i          (cnt_hi),
        .cnt_data_i        (cnt_data),
        .instret_o         (instret),
        .retire_valid_o    (retire_valid),
        .retire_pc_o       (retire_pc),
        .retire_rd_addr_o  (retire_rd_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".ready"},   a.ready,   e.ready);
        check({tag, ".hz"},      a.hz,      e.hz);
        check({tag, ".rs1"},     a.rs1,     e.rs1);
        check({tag, ".rs2"},     a.rs2,     e.rs2);
        check({tag, ".rv"},      a.rv,      e.rv);
        check({tag, ".rpc"},     a.rpc,     e.rpc);
        check({tag, ".rrd"},     a.rrd,     e.rrd);
        check({tag, ".instret"}, a.instret, e.instret);
    endtask

    function automatic vec_t v(input logic valid, halt, input logic [29:0] pc, input logic [4:0] rd,
                               input logic [31:0] data, input logic [4:0] rs1, rs2,
                               input logic inh, we, hi, input logic [31:0] cd,
                               input logic ready, input logic [4:0] hz, input logic [31:0] e1, e2,
                               input logic rv, input logic [29:0] rpc, input logic [4:0] rrd,
                               input logic [63:0] ic);
        vec_t r;
        r.s = '{valid, halt, pc, rd, data, rs1, rs2, inh, we, hi, cd};
        r.e = '{ready, hz, e1, e2, rv, rpc, rrd, ic};
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;
        m_rpc = TAG;
        m_rrd = '0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input stim_t s, input logic acc);
        if (a == 5'd0) return '0;
        if (BYP && acc && s.rd != 5'd0 && a == s.rd) return s.data;
        return m_regs[a];
    endfunction

    // Expected outputs for one cycle, from the model state before the clock edge.
    function automatic obs_t predict(input stim_t s);
        obs_t e;
        logic acc;
        acc       = s.valid && !s.halt;
        e.ready   = !s.halt;
        e.hz      = acc ? s.rd : 5'd0;
        e.rs1     = model_read(s.rs1, s, acc);
        e.rs2     = model_read(s.rs2, s, acc);
        e.rv      = acc;
        e.rpc     = acc ? s.pc : m_rpc;
        e.rrd     = acc ? s.rd : m_rrd;
        if (s.we)                e.instret = s.hi ? {s.cd, m_cnt[31:0]} : {m_cnt[63:32], s.cd};
        else if (acc && !s.inh)  e.instret = m_cnt + 64'd1;
        else                     e.instret = m_cnt;
        return e;
    endfunction

    function automatic void commit(input stim_t s, input obs_t e);
        if (s.valid && !s.halt && s.rd != 5'd0) m_regs[s.rd] = s.data;
        m_cnt = e.instret;
        m_rpc = e.rpc;
        m_rrd = e.rrd;
    endfunction

    task automatic drive(input stim_t s);
        bus.valid   = s.valid;
        bus.pc      = s.pc;
        bus.rd_addr = s.rd;
        bus.rd_data = s.data;
        halt        = s.halt;
        rs1_addr    = s.rs1;
        rs2_addr    = s.rs2;
        inhibit     = s.inh;
        cnt_we      = s.we;
        cnt_hi      = s.hi;
        cnt_data    = s.cd;
    endtask

    // Called at posedge+1; samples combinational outputs mid-cycle and registered ones after the edge.
    task automatic run_cycle(input stim_t s, output obs_t o);
        obs_t e;
        e = predict(s);
        drive(s);
        #2;
        o.ready = bus.ready;
        o.hz    = hz_rd_addr;
        o.rs1   = rs1_data;
        o.rs2   = rs2_data;
        @(posedge clk);
        #1;
        o.rv      = retire_valid;
        o.rpc     = retire_pc;
        o.rrd     = retire_rd_addr;
        o.instret = instret;
        commit(s, e);
    endtask

    vec_t  tbl [$];
    stim_t s;
    obs_t  o, e;

    initial begin
        tbl.push_back(v(1,0,30'h100,5,32'hDEADBEEF,5,0,0,0,0,0, 1,5,BYP ? 32'hDEADBEEF : 32'h0,0,1,30'h100,5,64'd1));
        tbl.push_back(v(0,0,0,0,0,5,5,0,0,0,0,                  1,0,32'hDEADBEEF,32'hDEADBEEF,0,30'h100,5,64'd1));
        tbl.push_back(v(1,0,30'h101,0,32'h1234,0,5,0,0,0,0,     1,0,0,32'hDEADBEEF,1,30'h101,0,64'd2));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,                  1,0,0,0,0,30'h101,0,64'd2));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(1,1,30'h102,9,32'h99,9,5,0,0,0,0,   0,0,0,32'hDEADBEEF,0,30'h101,0,64'd2));
        tbl.push_back(v(1,0,30'h102,9,32'h99,9,5,0,0,0,0,       1,9,BYP ? 32'h99 : 32'h0,32'hDEADBEEF,1,30'h102,9,64'd3));
        tbl.push_back(v(0,0,0,0,0,9,0,0,0,0,0,                  1,0,32'h99,0,0,30'h102,9,64'd3));
        tbl.push_back(v(0,0,0,0,0,0,0,0,1,0,32'hFFFFFFFF,       1,0,0,0,0,30'h102,9,64'h0000_0000_FFFF_FFFF));
        tbl.push_back(v(1,0,30'h103,1,32'h11,0,0,0,0,0,0,       1,1,0,0,1,30'h103,1,64'h0000_0001_0000_0000));
        tbl.push_back(v(1,0,30'h104,2,32'h22,0,0,0,0,0,0,       1,2,0,0,1,30'h104,2,64'h0000_0001_0000_0001));
        tbl.push_back(v(1,0,30'h105,3,32'h33,0,0,0,1,1,32'h5,   1,3,0,0,1,30'h105,3,64'h0000_0005_0000_0001));
        tbl.push_back(v(1,0,30'h106,7,32'hA5A5,3,7,1,0,0,0,     1,7,32'h33,BYP ? 32'hA5A5 : 32'h0,1,30'h106,7,64'h0000_0005_0000_0001));
        tbl.push_back(v(0,0,0,0,0,7,7,0,0,0,0,                  1,0,32'hA5A5,32'hA5A5,0,30'h106,7,64'h0000_0005_0000_0001));
        tbl.push_back(v(0,0,0,0,0,1,2,0,1,1,32'hFFFFFFFF,       1,0,32'h11,32'h22,0,30'h106,7,64'hFFFF_FFFF_0000_0001));
        tbl.push_back(v(0,0,0,0,0,1,2,0,1,0,32'hFFFFFFFF,       1,0,32'h11,32'h22,0,30'h106,7,64'hFFFF_FFFF_FFFF_FFFF));
        tbl.push_back(v(1,0,30'h107,0,32'h55,0,3,0,0,0,0,       1,0,0,32'h33,1,30'h107,0,64'd0));

        // Reset state, checked while reset is still asserted.
        reset = 1'b1;
        s = '{0,0,0,0,0,5,31,0,0,0,0};
        drive(s);
        model_reset();
        #12;
        check("reset.rv", retire_valid, 1'b0);
        check("reset.instret", instret, 64'd0);
        check("reset.rpc", retire_pc, TAG);
        check("reset.rrd", retire_rd_addr, 5'd0);
        check("reset.rs1", rs1_data, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            run_cycle(tbl[i].s, o);
            compare_obs($sformatf("row%0d", i), o, tbl[i].e);
        end

        for (int n = 0; n < 300; n++) begin
            s.valid = ($urandom_range(0, 9) < 7);
            s.halt  = ($urandom_range(0, 3) == 0);
            s.pc    = 30'($urandom);
            s.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            s.data  = $urandom;
            s.rs1   = ($urandom_range(0, 2) == 0) ? s.rd : 5'($urandom);
            s.rs2   = ($urandom_range(0, 2) == 0) ? s.rs1 : 5'($urandom);
            s.inh   = ($urandom_range(0, 9) == 0);
            s.we    = ($urandom_range(0, 19) == 0);
            s.hi    = $urandom_range(0, 1) == 1;
            s.cd    = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : $urandom;
            e = predict(s);
            run_cycle(s, o);
            compare_obs($sformatf("rand%0d", n), o, e);
        end

        // Reset in the middle of an accepted beat: takes effect at once and the beat is lost.
        s = '{1,0,30'h3AB,4,32'h44,5,9,0,0,0,0};
        drive(s);
        #3;
        reset = 1'b1;
        #1;
        check("midrst.rv", retire_valid, 1'b0);
        check("midrst.instret", instret, 64'd0);
        check("midrst.rpc", retire_pc, TAG);
        check("midrst.rrd", retire_rd_addr, 5'd0);
        check("midrst.rs1", rs1_data, 32'd0);
        check("midrst.rs2", rs2_data, 32'd0);
        @(posedge clk);
        #1;
        check("midrst_edge.rv", retire_valid, 1'b0);
        check("midrst_edge.instret", instret, 64'd0);
        bus.valid = 1'b0;
        #2;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        s = '{0,0,0,0,0,4,31,0,0,0,0};
        e = predict(s);
        run_cycle(s, o);
        compare_obs("postrst", o, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
